// File: rtl/guess_datapath.sv
// guess_datapath: datapath stage for the guessing-game controller.
//   Generates the secret "actual" value with a wrapping counter, synchronises
//   the switch guess, registers over/under/equal compare flags for the FSM,
//   and holds the three result LEDs until the FSM commands an update.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset (clears every register)
//   i_guess        raw switch value, asynchronous to clk
//   i_inc_actual   advance the actual counter this cycle
//   i_update_leds  copy the current flag registers into the LED registers
//   o_over         registered: synchronised guess > actual
//   o_under        registered: synchronised guess < actual
//   o_equal        registered: synchronised guess == actual
//   o_led_over     held LED copy of o_over
//   o_led_under    held LED copy of o_under
//   o_led_equal    held LED copy of o_equal
//   o_actual       current actual value (debug / seven-segment)
module guess_datapath #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_guess,
  input  logic             i_inc_actual,
  input  logic             i_update_leds,
  output logic             o_over,
  output logic             o_under,
  output logic             o_equal,
  output logic             o_led_over,
  output logic             o_led_under,
  output logic             o_led_equal,
  output logic [WIDTH-1:0] o_actual
);

  localparam logic [WIDTH-1:0] MAX_ACTUAL = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] g_sync;
  logic [WIDTH-1:0] actual;

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      g1     <= '0;
      g_sync <= '0;
    end else begin
      g1     <= i_guess;
      g_sync <= g1;
    end
  end

  // Secret value counter; wraps to zero after MAX_ACTUAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      actual <= '0;
    end else if (i_inc_actual) begin
      if (actual == MAX_ACTUAL) actual <= '0;
      else                      actual <= actual + WIDTH'(1);
    end
  end

  // Unsigned compare, registered every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_over  <= 1'b0;
      o_under <= 1'b0;
      o_equal <= 1'b0;
    end else begin
      o_over  <= (g_sync >  actual);
      o_under <= (g_sync <  actual);
      o_equal <= (g_sync == actual);
    end
  end

  // LEDs capture the flag registers as they stand at the update edge,
  // so a same-cycle increment or guess change is not yet reflected.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_led_over  <= 1'b0;
      o_led_under <= 1'b0;
      o_led_equal <= 1'b0;
    end else if (i_update_leds) begin
      o_led_over  <= o_over;
      o_led_under <= o_under;
      o_led_equal <= o_equal;
    end
  end

  assign o_actual = actual;

endmodule

// File: tb/tb_guess_datapath.sv
// tb_guess_datapath: directed plus randomized bench for guess_datapath,
//   checked cycle by cycle against a behavioural model (modular counter,
//   guess history queue) and at key points against fixed constants.
module tb_guess_datapath;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned MAXV  = 250;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] i_guess;
  logic             i_inc_actual;
  logic             i_update_leds;
  logic             o_over, o_under, o_equal;
  logic             o_led_over, o_led_under, o_led_equal;
  logic [WIDTH-1:0] o_actual;

  guess_datapath #(.WIDTH(WIDTH), .MAX_VALUE(MAXV)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_guess       (i_guess),
    .i_inc_actual  (i_inc_actual),
    .i_update_leds (i_update_leds),
    .o_over        (o_over),
    .o_under       (o_under),
    .o_equal       (o_equal),
    .o_led_over    (o_led_over),
    .o_led_under   (o_led_under),
    .o_led_equal   (o_led_equal),
    .o_actual      (o_actual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int m_actual;
  int hist[$];                 // guesses in flight: hist[0] is the one the compare sees
  int m_flag[3];               // over, under, equal
  int m_led[3];

  function automatic void model_edge();
    int seen;
    if (reset) begin
      m_actual = 0;
      hist = '{0, 0};
      m_flag = '{0, 0, 0};
      m_led  = '{0, 0, 0};
    end else begin
      seen = hist[0];
      if (i_update_leds) m_led = m_flag;
      m_flag[0] = (seen >  m_actual) ? 1 : 0;
      m_flag[1] = (seen <  m_actual) ? 1 : 0;
      m_flag[2] = (seen == m_actual) ? 1 : 0;
      m_actual = (m_actual + (i_inc_actual ? 1 : 0)) % (MAXV + 1);
      void'(hist.pop_front());
      hist.push_back(int'(i_guess));
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("actual",    32'(o_actual),    32'(m_actual));
    check("over",      32'(o_over),      32'(m_flag[0]));
    check("under",     32'(o_under),     32'(m_flag[1]));
    check("equal",     32'(o_equal),     32'(m_flag[2]));
    check("led_over",  32'(o_led_over),  32'(m_led[0]));
    check("led_under", 32'(o_led_under), 32'(m_led[1]));
    check("led_equal", 32'(o_led_equal), 32'(m_led[2]));
  endtask

  // One clock: model follows the same edge, outputs sampled 1 time unit later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    m_actual = 0; hist = '{0, 0}; m_flag = '{0, 0, 0}; m_led = '{0, 0, 0};
    reset = 1'b1; i_guess = 8'h55; i_inc_actual = 1'b1; i_update_leds = 1'b1;

    // Reset has priority over inc and update
    step(2);
    check("rst_actual", 32'(o_actual), 0);
    check("rst_flags",  32'({o_over, o_under, o_equal}), 0);
    check("rst_leds",   32'({o_led_over, o_led_under, o_led_equal}), 0);

    // First cycle after reset: guess 0 vs actual 0
    reset = 1'b0; i_guess = '0; i_inc_actual = 1'b0; i_update_leds = 1'b0;
    step();
    check("post_rst_flags", 32'({o_over, o_under, o_equal}), 32'(3'b001));

    // Count through the wrap: 253 increments land on 2
    i_inc_actual = 1'b1;
    step(253);
    check("wrap_val", 32'(o_actual), 2);
    i_inc_actual = 1'b0;
    step(5);
    check("hold_val", 32'(o_actual), 2);

    // Simultaneous inc and update: actual 4, guess 5
    i_inc_actual = 1'b1; step(2); i_inc_actual = 1'b0;
    i_guess = 8'd5; step(3);
    check("pre_sim_over", 32'(o_over), 1);
    i_inc_actual = 1'b1; i_update_leds = 1'b1; step();
    check("sim_led_over", 32'(o_led_over), 1);
    check("sim_actual",   32'(o_actual), 5);
    i_inc_actual = 1'b0; i_update_leds = 1'b0; step();
    check("sim_equal",    32'(o_equal), 1);

    // Compare latency: actual 5, guess 3 -> 7
    i_guess = 8'd3; step(3);
    i_guess = 8'd7;
    step(); check("lat_e1_under", 32'(o_under), 1);
    step(); check("lat_e2_under", 32'(o_under), 1);
    step(); check("lat_e3_over",  32'(o_over), 1);
    i_guess = 8'd5; step(2);
    check("lat_eq_not_yet", 32'(o_equal), 0);
    step(); check("lat_eq", 32'(o_equal), 1);

    // LED hold
    i_guess = 8'd7; step(3);
    i_update_leds = 1'b1; step(); i_update_leds = 1'b0;
    i_guess = 8'd2; step(8);
    check("hold_leds",  32'({o_led_over, o_led_under, o_led_equal}), 32'(3'b100));
    check("hold_under", 32'(o_under), 1);

    // Guess above MAX_VALUE is legal and reads as over
    i_guess = 8'd255; step(3);
    check("above_max_over", 32'(o_over), 1);

    // Mid-operation reset: actual 200, LEDs 0/0/1
    i_guess = 8'd200; i_inc_actual = 1'b1; step(195); i_inc_actual = 1'b0;
    step(3);
    i_update_leds = 1'b1; step(); i_update_leds = 1'b0;
    check("mid_leds",   32'({o_led_over, o_led_under, o_led_equal}), 32'(3'b001));
    check("mid_actual", 32'(o_actual), 200);
    reset = 1'b1; i_update_leds = 1'b1; step();
    check("mid_rst_all", 32'({o_over, o_under, o_equal, o_led_over, o_led_under, o_led_equal, o_actual}), 0);
    reset = 1'b0; i_update_leds = 1'b0; i_inc_actual = 1'b1; step(3);
    check("restart_count", 32'(o_actual), 3);
    i_inc_actual = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      i_guess       = WIDTH'($urandom_range(0, 255));
      i_inc_actual  = ($urandom_range(0, 3) != 0);
      i_update_leds = ($urandom_range(0, 4) == 0);
      reset         = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; i_inc_actual = 1'b0; i_update_leds = 1'b0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/guess_datapath.md
Name: guess_datapath

Overview:
Datapath stage paired with the guessing-game control FSM. It generates the secret "actual" number with a free-running wrap counter that advances while the FSM requests it. It synchronises the switch guess and compares it against actual, producing registered over/under/equal flags for the FSM. It also holds the three result LEDs, which change only when the FSM commands an update.

Parameters:
WIDTH, 8, bit width of guess and actual values
MAX_VALUE, 255, largest value actual reaches before wrapping to 0; must satisfy MAX_VALUE <= 2^WIDTH-1

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_guess  input  WIDTH  raw switch value; asynchronous to clk
i_inc_actual  input  1  from FSM; advance actual counter this cycle
i_update_leds  input  1  from FSM; copy current flags to LED registers
o_over  output  1  registered: guess > actual
o_under  output  1  registered: guess < actual
o_equal  output  1  registered: guess == actual
o_led_over  output  1  held LED copy of o_over
o_led_under  output  1  held LED copy of o_under
o_led_equal  output  1  held LED copy of o_equal
o_actual  output  WIDTH  current actual value; debug/seven-segment only

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset. No asynchronous reset path anywhere.
- Reset, sampled on a clk edge while high, sets every register to 0:
  - actual = 0
  - both guess synchroniser stages = 0
  - o_over = o_under = o_equal = 0
  - all LED registers = 0
- Reset applies mid-operation with the same result, and has priority over every other input.
- Guess synchroniser:
  - Two flop stages: g1 <= i_guess; g_sync <= g1.
  - Only g_sync feeds the compare logic.
- Actual counter:
  - If i_inc_actual = 1: if actual == MAX_VALUE, actual <= 0, else actual <= actual + 1.
  - If i_inc_actual = 0: actual holds.
  - Arithmetic is unsigned WIDTH-bit. No value above MAX_VALUE is ever stored.
- Compare, registered every cycle, never gated:
  - o_over <= (g_sync > actual)
  - o_under <= (g_sync < actual)
  - o_equal <= (g_sync == actual)
  - Comparison is unsigned.
  - From the first cycle after reset deasserts, exactly one flag is high. In the reset cycle itself all three flags are 0.
  - A guess above MAX_VALUE is legal and yields o_over.
- Latency:
  - i_guess change to flags: 3 clk edges (2 synchroniser stages plus the compare register).
  - Actual change to flags: 1 clk edge.
- Flags seen by the FSM in a given cycle reflect actual from the previous cycle. The FSM stops incrementing many cycles before its compare state, so no hazard arises.
- LEDs:
  - When i_update_leds = 1: {o_led_over, o_led_under, o_led_equal} <= {o_over, o_under, o_equal}, i.e. the flag register values present at that edge.
  - Otherwise the LEDs hold.
- Simultaneous i_inc_actual and i_update_leds: both take effect. The LEDs capture the flags computed from the pre-increment actual.
- Simultaneous i_guess change and i_update_leds: the LEDs capture the old flags. The new guess is not visible for 3 edges.
- o_actual is a direct output of the actual register, with no added latency.

Test Plan:
- Reset behaviour: assert reset 2 cycles with i_inc_actual=1, i_update_leds=1 -> actual=0, all flags and LEDs 0. One cycle after deassert with i_guess=0, inc=0 -> o_equal=1, o_over=o_under=0.
- Counting and wrap: MAX_VALUE=9, hold i_inc_actual=1 for 12 cycles from reset -> o_actual runs 1..9, 0, 1, 2. Deassert inc -> o_actual holds at 2 for 5 cycles.
- Compare latency: actual=5 held, i_guess steps from 3 to 7 -> o_under stays 1 for 2 edges, then o_over=1 at the 3rd edge. i_guess=5 -> o_equal=1 three edges later.
- LED hold: guess=7, actual=5, pulse i_update_leds 1 cycle -> o_led_over=1. Then change guess to 2 with no update -> LEDs remain 1/0/0 indefinitely while o_under=1.
- Simultaneous events: actual=4, guess=5, o_over=1; assert inc and update in the same cycle -> o_led_over=1, actual=5, and next cycle o_equal=1.
- Reset mid-operation: LEDs showing 0/0/1, actual=200, assert reset 1 cycle -> all outputs 0 at that edge. Actual restarts counting from 0 when inc resumes.
